// File: rtl/alu_writeback_pkg.sv
// Shared writeback types and helpers: write-size encoding, RFLAGS reset value,
// the buffered ALU-result entry and the x86 partial-width / flag merge functions.
package alu_writeback_pkg;

  localparam int NREGS        = 16;
  localparam int DATA_W       = 64;
  localparam int REG_AW       = $clog2(NREGS);
  localparam logic [DATA_W-1:0] RFLAGS_RESET = 64'h2;

  typedef enum logic [1:0] {
    SZ8  = 2'd0,
    SZ16 = 2'd1,
    SZ32 = 2'd2,
    SZ64 = 2'd3
  } wb_size_t;

  typedef struct packed {
    logic              wr_en;
    logic [REG_AW-1:0] dst;
    wb_size_t          size;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] flags;
    logic [DATA_W-1:0] mask;
  } wb_entry_t;

  // 32-bit writes zero-extend; 8/16-bit writes keep the untouched upper bits.
  function automatic logic [DATA_W-1:0] wb_merge(input logic [DATA_W-1:0] old_val,
                                                 input logic [DATA_W-1:0] res,
                                                 input wb_size_t          size);
    case (size)
      SZ8:     return {old_val[DATA_W-1:8], res[7:0]};
      SZ16:    return {old_val[DATA_W-1:16], res[15:0]};
      SZ32:    return {{(DATA_W-32){1'b0}}, res[31:0]};
      default: return res;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] wb_flags_merge(input logic [DATA_W-1:0] old_val,
                                                       input logic [DATA_W-1:0] flags,
                                                       input logic [DATA_W-1:0] mask);
    logic [DATA_W-1:0] f;
    f    = (old_val & ~mask) | (flags & mask);
    f[1] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; pointers and count reset, storage does not.
module wb_fifo
  import alu_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                wdata,
  output wb_entry_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: buffers results, commits one per cycle into the GPR file and RFLAGS.
// Define ALU_WB_BYPASS_EN to forward the committing head entry onto the read ports.
module alu_writeback #(
  parameter int NREGS      = 16,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_wr_en,
  input  logic [$clog2(NREGS)-1:0] in_dst,
  input  logic [1:0]               in_size,
  input  logic [DATA_W-1:0]        in_result,
  input  logic [DATA_W-1:0]        in_flags,
  input  logic [DATA_W-1:0]        in_flags_mask,
  input  logic                     commit_hold,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  output logic [DATA_W-1:0]        rs1_data,
  output logic [DATA_W-1:0]        rs2_data,
  output logic [DATA_W-1:0]        rflags,
  output logic [31:0]              retire_count
);
  import alu_writeback_pkg::*;

  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t          in_entry;
  wb_entry_t          head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic               unused_fifo_full;
  logic               push;
  logic               commit;
  logic [DATA_W-1:0]  head_merged;
  logic [DATA_W-1:0]  gpr [NREGS];

  assign in_entry = '{wr_en:  in_wr_en,
                      dst:    in_dst,
                      size:   wb_size_t'(in_size),
                      result: in_result,
                      flags:  in_flags,
                      mask:   in_flags_mask};

  // Ready comes from the registered occupancy only, so a full buffer never
  // accepts even when a commit frees a slot on the same edge.
  assign in_ready         = (fifo_count != CW'(FIFO_DEPTH));
  assign unused_fifo_full = fifo_full;
  assign push             = in_valid & in_ready;
  assign commit           = ~fifo_empty & ~commit_hold & ~reset;
  assign head_merged      = wb_merge(gpr[head.dst], head.result, head.size);

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (commit),
    .wdata (in_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
      rflags       <= RFLAGS_RESET;
      retire_count <= '0;
    end else if (commit) begin
      if (head.wr_en) gpr[head.dst] <= head_merged;
      rflags       <= wb_flags_merge(rflags, head.flags, head.mask);
      retire_count <= retire_count + 32'd1;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0] addr);
    logic [DATA_W-1:0] v;
    v = gpr[addr];
`ifdef ALU_WB_BYPASS_EN
    if (commit && head.wr_en && (head.dst == addr)) v = head_merged;
`endif
    return v;
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized plus directed bench for alu_writeback against a queue-based reference model.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wr_en = 1'b0;
  logic [3:0]  in_dst = '0;
  logic [1:0]  in_size = '0;
  logic [63:0] in_result = '0;
  logic [63:0] in_flags = '0;
  logic [63:0] in_flags_mask = '0;
  logic        commit_hold = 1'b0;
  logic [3:0]  rs1_addr = '0;
  logic [3:0]  rs2_addr = '0;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [63:0] rflags;
  logic [31:0] retire_count;

  always #5 clk = ~clk;

  alu_writeback #(.NREGS(16), .DATA_W(64), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_wr_en      (in_wr_en),
    .in_dst        (in_dst),
    .in_size       (in_size),
    .in_result     (in_result),
    .in_flags      (in_flags),
    .in_flags_mask (in_flags_mask),
    .commit_hold   (commit_hold),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .rflags        (rflags),
    .retire_count  (retire_count)
  );

  typedef struct {
    bit          wr_en;
    int          dst;
    int          size;
    logic [63:0] result;
    logic [63:0] flags;
    logic [63:0] mask;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_gpr [16];
  logic [63:0] m_rflags;
  logic [31:0] m_retire;
  bit          m_known = 0;
  int          n_total = 0;
  int          n_bad = 0;
  logic [63:0] obs_rs2;
  logic        obs_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // x86 partial-width register write, expressed on byte/word/dword lanes.
  function automatic logic [63:0] ref_write(input logic [63:0] old_val,
                                            input logic [63:0] res, input int size);
    logic [63:0] r;
    case (size)
      0:       r = {old_val[63:8], res[7:0]};
      1:       r = {old_val[63:16], res[15:0]};
      2:       r = {32'h0, res[31:0]};
      default: r = res;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] ref_read(input int addr);
    logic [63:0] v;
    v = m_gpr[addr];
`ifdef ALU_WB_BYPASS_EN
    if (!reset && !commit_hold && q.size() > 0 && q[0].wr_en && q[0].dst == addr)
      v = ref_write(m_gpr[addr], q[0].result, q[0].size);
`endif
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 16; i++) m_gpr[i] = 64'h0;
    m_rflags = 64'h2;
    m_retire = 32'h0;
    m_known  = 1;
  endtask

  task automatic cycle(input bit rst, input bit v, input bit we, input int dst, input int sz,
                       input logic [63:0] res, input logic [63:0] fl, input logic [63:0] mk,
                       input bit hold, input int a1, input int a2);
    bit   acc;
    ent_t e;
    @(negedge clk);
    reset         = rst;
    in_valid      = v;
    in_wr_en      = we;
    in_dst        = 4'(dst);
    in_size       = 2'(sz);
    in_result     = res;
    in_flags      = fl;
    in_flags_mask = mk;
    commit_hold   = hold;
    rs1_addr      = 4'(a1);
    rs2_addr      = 4'(a2);
    #1;
    obs_rs2   = rs2_data;
    obs_ready = in_ready;
    if (m_known) begin
      chk("in_ready", {63'h0, in_ready}, {63'h0, q.size() < 2});
      chk("rs1_data", rs1_data, ref_read(a1));
      chk("rs2_data", rs2_data, ref_read(a2));
      chk("rflags", rflags, m_rflags);
      chk("retire_count", {32'h0, retire_count}, {32'h0, m_retire});
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      acc = v && (q.size() < 2);
      if (q.size() > 0 && !hold) begin
        e = q.pop_front();
        if (e.wr_en) m_gpr[e.dst] = ref_write(m_gpr[e.dst], e.result, e.size);
        m_rflags    = (m_rflags & ~e.mask) | (e.flags & e.mask);
        m_rflags[1] = 1'b1;
        m_retire    = m_retire + 32'd1;
      end
      if (acc) begin
        e.wr_en = we; e.dst = dst; e.size = sz; e.result = res; e.flags = fl; e.mask = mk;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int a1, input int a2, input bit hold);
    cycle(0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, hold, a1, a2);
  endtask

  task automatic push(input bit we, input int dst, input int sz, input logic [63:0] res,
                      input logic [63:0] fl, input logic [63:0] mk, input bit hold);
    cycle(0, 1, we, dst, sz, res, fl, mk, hold, dst, dst);
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 0, 0, 0);
    idle(7, 12, 0);
    #1;
    chk("rst_rs1", rs1_data, 64'h0);
    chk("rst_rs2", rs2_data, 64'h0);
    chk("rst_rflags", rflags, 64'h2);
    chk("rst_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_retire", {32'h0, retire_count}, 64'h0);

    push(1, 0, 3, 64'hDEAD_BEEF_0123_4567, 64'h0, 64'h0, 0);
    idle(0, 0, 0);
    #1;
    chk("full_write", rs1_data, 64'hDEAD_BEEF_0123_4567);
    chk("full_retire", {32'h0, retire_count}, 64'h1);

    push(1, 0, 3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 0);
    idle(0, 0, 0);
    push(1, 0, 2, 64'h5555_5555_0000_0001, 64'h0, 64'h0, 0);
    idle(0, 0, 0);
    #1;
    chk("sz32_zext", rs1_data, 64'h0000_0000_0000_0001);
    push(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0, 64'h0, 0);
    idle(0, 0, 0);
    #1;
    chk("sz8_merge", rs1_data, 64'h0000_0000_0000_00AB);
    push(1, 0, 1, 64'hFFFF_FFFF_FFFF_1234, 64'h0, 64'h0, 0);
    idle(0, 0, 0);
    #1;
    chk("sz16_merge", rs1_data, 64'h0000_0000_0000_1234);

    push(0, 0, 3, 64'h0, 64'h41, 64'h8D5, 0);
    idle(0, 0, 0);
    #1;
    chk("flags_only", rflags, 64'h43);
    chk("flags_gpr_kept", rs1_data, 64'h0000_0000_0000_1234);

    push(1, 5, 3, 64'h1, 64'h0, 64'h0, 1);
    push(1, 5, 3, 64'h2, 64'h0, 64'h0, 1);
    push(1, 5, 3, 64'h3, 64'h0, 64'h0, 1);
    chk("bp_not_ready", {63'h0, obs_ready}, 64'h0);
    push(1, 5, 3, 64'h3, 64'h0, 64'h0, 0);
    #1;
    chk("bp_first", rs1_data, 64'h1);
    push(1, 5, 3, 64'h3, 64'h0, 64'h0, 0);
    #1;
    chk("bp_second", rs1_data, 64'h2);
    idle(5, 5, 0);
    #1;
    chk("bp_third", rs1_data, 64'h3);
    idle(5, 5, 0);
    #1;
    chk("bp_retire", {32'h0, retire_count}, 64'd9);

    cycle(1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 0, 0, 0);
    push(1, 3, 3, 64'h5, 64'h0, 64'h0, 1);
    idle(0, 3, 0);
`ifdef ALU_WB_BYPASS_EN
    chk("bypass_same", obs_rs2, 64'h5);
`else
    chk("nobypass_old", obs_rs2, 64'h0);
`endif
    #1;
    chk("bypass_next", rs2_data, 64'h5);

    push(1, 7, 3, 64'hAA, 64'h0, 64'h0, 1);
    push(1, 7, 3, 64'hBB, 64'h0, 64'h0, 1);
    cycle(1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 0, 7, 7);
    idle(7, 7, 0);
    idle(7, 7, 0);
    #1;
    chk("rst_drop_gpr", rs1_data, 64'h0);
    chk("rst_drop_retire", {32'h0, retire_count}, 64'h0);
    chk("rst_drop_ready", {63'h0, in_ready}, 64'h1);

    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(99) == 0, $urandom_range(9) < 7, $urandom_range(3) != 0,
            int'($urandom_range(15)), int'($urandom_range(3)), {$urandom, $urandom},
            {$urandom, $urandom}, ($urandom_range(3) == 0) ? 64'h0 : {$urandom, $urandom},
            $urandom_range(9) < 3, int'($urandom_range(15)), int'($urandom_range(15)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
